// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
//   Sequential store path for the RV32I core. Takes one store request
//   (funct3, byte address, rs2 data) per handshake, aligns the data into
//   32-bit word lanes with byte enables, and issues one memory write beat,
//   or two beats when an SH/SW crosses a word boundary.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req_valid       store request valid
//   o_req_ready       unit idle and accepting (state == IDLE)
//   i_funct3          000=SB, 001=SH, 010=SW; other codes are dropped with o_err
//   i_addr            byte address of the store
//   i_wdata           rs2 data (SB uses [7:0], SH uses [15:0])
//   o_mem_valid       write beat valid
//   i_mem_ready       memory accepts the beat when o_mem_valid && i_mem_ready
//   o_mem_addr        word-aligned beat address
//   o_mem_wdata       lane-aligned write data, disabled lanes are zero
//   o_mem_be          byte enables, bit n = byte lane n
//   o_done            one-cycle pulse, request fully written
//   o_misaligned      valid with o_done, 1 when two beats were used
//   o_err             one-cycle pulse, illegal funct3 accepted and dropped
// -----------------------------------------------------------------------------
module store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  output logic              o_done,
  output logic              o_misaligned,
  output logic              o_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q,    mem_be_d;
  logic [ADDR_W-1:0] b1_addr_q,   b1_addr_d;
  logic [31:0]       b1_wdata_q,  b1_wdata_d;
  logic [3:0]        b1_be_q,     b1_be_d;
  logic              need_b1_q,   need_b1_d;
  logic              done_q,      done_d;
  logic              misal_q,     misal_d;
  logic              err_q,       err_d;

  // Request lane math
  logic              legal;
  logic [3:0]        mask;
  logic [31:0]       data_sized;
  logic [7:0]        be8;
  logic [63:0]       d64;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] next_addr;

  always_comb begin
    legal      = 1'b1;
    mask       = 4'b0000;
    data_sized = 32'h0;
    case (i_funct3)
      3'b000: begin
        mask       = 4'b0001;
        data_sized = {24'h0, i_wdata[7:0]};
      end
      3'b001: begin
        mask       = 4'b0011;
        data_sized = {16'h0, i_wdata[15:0]};
      end
      3'b010: begin
        mask       = 4'b1111;
        data_sized = i_wdata;
      end
      default: legal = 1'b0;
    endcase
    // Shifting into an 8-lane window: the upper four lanes spill into the
    // following word and become the second beat.
    be8       = {4'b0000, mask} << i_addr[1:0];
    d64       = {32'h0, data_sized} << {i_addr[1:0], 3'b000};
    base_addr = {i_addr[ADDR_W-1:2], 2'b00};
    next_addr = base_addr + ADDR_W'(4);
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
      b1_addr_q   <= '0;
      b1_wdata_q  <= 32'h0;
      b1_be_q     <= 4'b0000;
      need_b1_q   <= 1'b0;
      done_q      <= 1'b0;
      misal_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      b1_addr_q   <= b1_addr_d;
      b1_wdata_q  <= b1_wdata_d;
      b1_be_q     <= b1_be_d;
      need_b1_q   <= need_b1_d;
      done_q      <= done_d;
      misal_q     <= misal_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic. Memory outputs hold by default, which keeps them
  // stable through any number of stall cycles.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    b1_addr_d   = b1_addr_q;
    b1_wdata_d  = b1_wdata_q;
    b1_be_d     = b1_be_q;
    need_b1_d   = need_b1_q;
    done_d      = 1'b0;
    misal_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          if (legal) begin
            state_d     = BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = base_addr;
            mem_wdata_d = d64[31:0];
            mem_be_d    = be8[3:0];
            b1_addr_d   = next_addr;
            b1_wdata_d  = d64[63:32];
            b1_be_d     = be8[7:4];
            need_b1_d   = |be8[7:4];
          end else begin
            err_d = 1'b1;
          end
        end
      end

      BEAT0: begin
        if (i_mem_ready) begin
          if (need_b1_q) begin
            // Second beat loaded straight into the output registers so the
            // valid stays high with no bubble between beats.
            state_d     = BEAT1;
            mem_addr_d  = b1_addr_q;
            mem_wdata_d = b1_wdata_q;
            mem_be_d    = b1_be_q;
          end else begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = 32'h0;
            mem_be_d    = 4'b0000;
            done_d      = 1'b1;
          end
        end
      end

      BEAT1: begin
        if (i_mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = 32'h0;
          mem_be_d    = 4'b0000;
          done_d      = 1'b1;
          misal_d     = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  assign o_req_ready  = (state_q == IDLE);
  assign o_mem_valid  = mem_valid_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_be     = mem_be_q;
  assign o_done       = done_q;
  assign o_misaligned = misal_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
//   Self-checking bench for store_unit. Directed vectors from a table, a
//   reset-during-second-beat sequence, then randomized stores checked against
//   a byte-level reference model. Inputs change and outputs are sampled on
//   the falling clock edge.
// -----------------------------------------------------------------------------
module tb_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        misaligned;
  logic        err;

  int checks = 0;
  int errors = 0;

  store_unit #(.ADDR_W(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_mem_valid  (mem_valid),
    .i_mem_ready  (mem_ready),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_be     (mem_be),
    .o_done       (done),
    .o_misaligned (misaligned),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    int          stall;
    int          n;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] d1;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: act=0x%08h exp=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: writes each stored byte to its own byte address and
  // groups the bytes by word; a byte landing outside the first word belongs
  // to the second beat.
  task automatic model(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output int n,
                       output logic [31:0] a0, output logic [3:0] be0,
                       output logic [31:0] d0, output logic [31:0] a1,
                       output logic [3:0] be1, output logic [31:0] d1);
    int size;
    logic [31:0] ba;
    size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
    a0 = a & 32'hFFFF_FFFC;
    a1 = a0 + 32'd4;
    be0 = 4'b0; be1 = 4'b0; d0 = 32'h0; d1 = 32'h0;
    for (int i = 0; i < size; i++) begin
      ba = a + 32'(i);
      if ((ba & 32'hFFFF_FFFC) == a0) begin
        be0[ba[1:0]] = 1'b1;
        d0[8*ba[1:0] +: 8] = d[8*i +: 8];
      end else begin
        be1[ba[1:0]] = 1'b1;
        d1[8*ba[1:0] +: 8] = d[8*i +: 8];
      end
    end
    n = (size == 0) ? 0 : (be1 != 4'b0) ? 2 : 1;
    if (n < 2) a1 = 32'h0;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] ea,
                            input logic [3:0] ebe, input logic [31:0] ed);
    check_output({tag, "_valid"}, {31'b0, mem_valid}, 32'd1);
    check_output({tag, "_addr"}, mem_addr, ea);
    check_output({tag, "_be"}, {28'b0, mem_be}, {28'b0, ebe});
    check_output({tag, "_wdata"}, mem_wdata, ed);
    check_output({tag, "_done"}, {31'b0, done}, 32'd0);
    check_output({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  // Issues one request at the current falling edge and follows it to
  // completion, stalling each beat for 'stall' cycles.
  task automatic apply_stimulus(input vec_t v);
    logic [31:0] ea [2];
    logic [3:0]  ebe[2];
    logic [31:0] ed [2];
    ea[0] = v.a0; ebe[0] = v.be0; ed[0] = v.d0;
    ea[1] = v.a1; ebe[1] = v.be1; ed[1] = v.d1;

    check_output("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    funct3    = v.f3;
    addr      = v.a;
    wdata     = v.d;
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    funct3    = $urandom_range(0, 7);
    addr      = $urandom;
    wdata     = $urandom;

    if (v.n == 0) begin
      check_output("err_pulse", {31'b0, err}, 32'd1);
      check_output("err_no_beat", {31'b0, mem_valid}, 32'd0);
      check_output("err_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      check_output("err_clear", {31'b0, err}, 32'd0);
      check_output("err_no_beat2", {31'b0, mem_valid}, 32'd0);
      return;
    end

    for (int b = 0; b < v.n; b++) begin
      for (int s = 0; s < v.stall; s++) begin
        mem_ready = 1'b0;
        check_beat($sformatf("stall%0d", b), ea[b], ebe[b], ed[b]);
        check_output("busy", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
      end
      mem_ready = 1'b1;
      check_beat($sformatf("beat%0d", b), ea[b], ebe[b], ed[b]);
      @(negedge clk);
    end
    mem_ready = $urandom_range(0, 1);
    check_output("done", {31'b0, done}, 32'd1);
    check_output("misaligned", {31'b0, misaligned}, (v.n == 2) ? 32'd1 : 32'd0);
    check_output("idle_valid", {31'b0, mem_valid}, 32'd0);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    rst = 1'b1; req_valid = 1'b0; funct3 = 3'b0; addr = 32'h0;
    wdata = 32'h0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_output("rst_ready", {31'b0, req_ready}, 32'd1);
    check_output("rst_valid", {31'b0, mem_valid}, 32'd0);
    check_output("rst_addr", mem_addr, 32'h0);
    check_output("rst_wdata", mem_wdata, 32'h0);
    check_output("rst_be", {28'b0, mem_be}, 32'h0);
    check_output("rst_done", {31'b0, done}, 32'd0);
    check_output("rst_misal", {31'b0, misaligned}, 32'd0);
    check_output("rst_err", {31'b0, err}, 32'd0);

    //            f3      addr           data        stl n  a0            be0      d0            a1            be1      d1
    vecs.push_back('{3'b010, 32'h0000_0100, 32'hDEADBEEF, 0, 1, 32'h0000_0100, 4'b1111, 32'hDEADBEEF, 32'h0, 4'b0000, 32'h0});
    vecs.push_back('{3'b000, 32'h0000_0203, 32'hFFFFFFA5, 0, 1, 32'h0000_0200, 4'b1000, 32'hA5000000, 32'h0, 4'b0000, 32'h0});
    vecs.push_back('{3'b001, 32'h0000_0202, 32'h00005678, 0, 1, 32'h0000_0200, 4'b1100, 32'h56780000, 32'h0, 4'b0000, 32'h0});
    vecs.push_back('{3'b001, 32'h0000_0303, 32'h00001234, 0, 2, 32'h0000_0300, 4'b1000, 32'h34000000, 32'h0000_0304, 4'b0001, 32'h00000012});
    vecs.push_back('{3'b010, 32'h0000_0402, 32'hAABBCCDD, 3, 2, 32'h0000_0400, 4'b1100, 32'hCCDD0000, 32'h0000_0404, 4'b0011, 32'h0000AABB});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'h11223344, 0, 2, 32'hFFFF_FFFC, 4'b1000, 32'h44000000, 32'h0000_0000, 4'b0111, 32'h00112233});
    vecs.push_back('{3'b011, 32'h0000_0500, 32'h12345678, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0});
    vecs.push_back('{3'b000, 32'h0000_0601, 32'h000000C3, 1, 1, 32'h0000_0600, 4'b0010, 32'h0000C300, 32'h0, 4'b0000, 32'h0});

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Reset while the second beat of a split SH is pending
    @(negedge clk);
    mem_ready = 1'b0;
    req_valid = 1'b1; funct3 = 3'b001; addr = 32'h0000_0303; wdata = 32'h00001234;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    check_beat("rb_beat0", 32'h0000_0300, 4'b1000, 32'h34000000);
    @(negedge clk);
    mem_ready = 1'b0;
    check_beat("rb_beat1", 32'h0000_0304, 4'b0001, 32'h00000012);
    rst = 1'b1;
    req_valid = 1'b1; funct3 = 3'b010; addr = 32'h0000_0700;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    check_output("rb_valid", {31'b0, mem_valid}, 32'd0);
    check_output("rb_done", {31'b0, done}, 32'd0);
    check_output("rb_ready", {31'b0, req_ready}, 32'd1);
    check_output("rb_be", {28'b0, mem_be}, 32'h0);
    @(negedge clk);
    check_output("rb_done2", {31'b0, done}, 32'd0);
    check_output("rb_valid2", {31'b0, mem_valid}, 32'd0);
    v = '{3'b010, 32'h0000_0800, 32'h01020304, 0, 1, 32'h0000_0800, 4'b1111, 32'h01020304, 32'h0, 4'b0000, 32'h0};
    apply_stimulus(v);

    // Randomized stores against the byte-level model
    for (int k = 0; k < 300; k++) begin
      v.f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                         : 3'($urandom_range(0, 2));
      v.a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                         : $urandom;
      v.d  = $urandom;
      v.stall = $urandom_range(0, 2);
      model(v.f3, v.a, v.d, v.n, v.a0, v.be0, v.d0, v.a1, v.be1, v.d1);
      apply_stimulus(v);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
